data_plane_link_fifo: RTL and testbench

Receive-side link buffer between the data-plane interconnect and `data_plane_rx`. It accepts 32-bit packets from the link and filters them by destination node id. Accepted packets are queued in a FIFO and replayed one per cycle onto `data_rx_packet`. Because `data_plane_rx` has no valid input, this block drives the all-zero idle word on every cycle it has no packet to present.

---
 rtl/data_plane_link_fifo.sv | 105 ++++++++++
 tb/tb_data_plane_link_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_plane_link_fifo.sv
// Receive-side link buffer: filters link packets by destination id, queues them and
// replays one per cycle to data_plane_rx, driving 32'h0 when idle. Optional: DP_LINK_DROP_CNT_EN.
module data_plane_link_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   node_id,
    input  logic [31:0]   link_packet,
    input  logic          link_valid,
    output logic          link_ready,
    input  logic          rx_hold,
    output logic [31:0]   data_rx_packet,
    output logic [AW:0]   fifo_count,
    output logic          overflow
`ifdef DP_LINK_DROP_CNT_EN
    ,
    output logic [7:0]    drop_count
`endif
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic [31:0]   data_reg;
    logic          overflow_reg;

    logic is_pkt;
    logic dest_match;
    logic accept;
    logic full;
    logic push;
    logic pop;

    // The all-zero word is the link idle code and never counts as a packet.
    assign is_pkt     = link_valid && (link_packet != 32'h0);
    assign dest_match = (link_packet[31:16] == node_id) || (link_packet[31:16] == 16'hFFFF);
    assign accept     = is_pkt && dest_match;
    assign full       = (count_reg == (AW+1)'(DEPTH));
    assign push       = accept && !full;
    assign pop        = (count_reg != '0) && !rx_hold;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= link_packet;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            data_reg     <= 32'h0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                data_reg   <= mem[rd_ptr_reg];
            end else begin
                data_reg   <= 32'h0;
            end
            count_reg <= count_next;
            if (accept && full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

`ifdef DP_LINK_DROP_CNT_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_reg <= 8'h0;
        end else if (is_pkt && !dest_match && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'h1;
        end
    end

    assign drop_count = drop_cnt_reg;
`endif

    assign link_ready     = !full;
    assign data_rx_packet = data_reg;
    assign fifo_count     = count_reg;
    assign overflow       = overflow_reg;

endmodule

// File: tb/tb_data_plane_link_fifo.sv
// Self-checking bench for data_plane_link_fifo: queue-based reference model compared
// every cycle, plus directed literal checks from the test plan and a random phase.
module tb_data_plane_link_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] node_id;
    logic [31:0] link_packet;
    logic        link_valid;
    logic        rx_hold;
    logic        link_ready;
    logic [31:0] data_rx_packet;
    logic [AW:0] fifo_count;
    logic        overflow;
`ifdef DP_LINK_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    data_plane_link_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .node_id        (node_id),
        .link_packet    (link_packet),
        .link_valid     (link_valid),
        .link_ready     (link_ready),
        .rx_hold        (rx_hold),
        .data_rx_packet (data_rx_packet),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
`ifdef DP_LINK_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted packets and the word presented after each edge.
    logic [31:0] q[$];
    logic [31:0] m_out;
    logic        m_ovf;
    int          m_drops;

    always @(posedge clk or negedge rst) begin
        int  sz;
        bit  do_pop;
        if (!rst) begin
            q.delete();
            m_out   = 32'h0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            sz     = q.size();
            do_pop = (sz != 0) && !rx_hold;
            if (link_valid && link_packet != 32'h0) begin
                if (link_packet[31:16] == node_id || link_packet[31:16] == 16'hFFFF) begin
                    if (sz == DEPTH) m_ovf = 1'b1;
                    else             q.push_back(link_packet);
                end else if (m_drops < 255) begin
                    m_drops++;
                end
            end
            if (do_pop) m_out = q.pop_front();
            else        m_out = 32'h0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("model_data",     data_rx_packet, m_out);
            chk("model_count",    32'(fifo_count), 32'(q.size()));
            chk("model_ready",    32'(link_ready), 32'(q.size() != DEPTH));
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
`ifdef DP_LINK_DROP_CNT_EN
            chk("model_drops",    32'(drop_count), 32'(m_drops));
`endif
        end
    end

    task automatic step(input logic v, input logic [31:0] p, input logic h);
        link_valid  = v;
        link_packet = p;
        rx_hold     = h;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && fifo_count != 0; i++) step(1'b0, 32'h0, 1'b0);
        chk("drain_bound", 32'(fifo_count), 32'h0);
        step(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] pkt;
        logic [15:0] dst;
        int          r;

        node_id     = 16'h0003;
        link_valid  = 1'b0;
        link_packet = 32'h0;
        rx_hold     = 1'b0;

        // Reset check
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("reset_ready",    32'(link_ready), 32'h1);
        chk("reset_count",    32'(fifo_count), 32'h0);
        chk("reset_data",     data_rx_packet, 32'h0);
        chk("reset_overflow", 32'(overflow), 32'h0);
        @(negedge clk);

        // Basic latency
        step(1'b1, 32'h0003_ABCD, 1'b0);
        chk("lat_n_data",  data_rx_packet, 32'h0);
        chk("lat_n_count", 32'(fifo_count), 32'h1);
        step(1'b0, 32'h0, 1'b0);
        chk("lat_n1_data", data_rx_packet, 32'h0003_ABCD);
        step(1'b0, 32'h0, 1'b0);
        chk("lat_n2_data", data_rx_packet, 32'h0);

        // Filtering
        step(1'b1, 32'h0005_1111, 1'b0);
        chk("filt_drop_count", 32'(fifo_count), 32'h0);
`ifdef DP_LINK_DROP_CNT_EN
        chk("filt_drop_cnt", 32'(drop_count), 32'h1);
`endif
        step(1'b1, 32'hFFFF_2222, 1'b0);
        chk("filt_bcast_count", 32'(fifo_count), 32'h1);
        step(1'b1, 32'h0, 1'b0);
        chk("filt_bcast_data", data_rx_packet, 32'hFFFF_2222);
        chk("filt_idle_count", 32'(fifo_count), 32'h0);
`ifdef DP_LINK_DROP_CNT_EN
        chk("filt_idle_drop", 32'(drop_count), 32'h1);
`endif
        step(1'b0, 32'h0, 1'b0);
        chk("filt_after_data", data_rx_packet, 32'h0);

        // Fill and overflow
        for (int i = 0; i < 9; i++) step(1'b1, 32'h0003_0000 + 32'(i), 1'b1);
        chk("fill_count",    32'(fifo_count), 32'h8);
        chk("fill_ready",    32'(link_ready), 32'h0);
        chk("fill_overflow", 32'(overflow), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b0);
            chk("fill_drain_data", data_rx_packet, 32'h0003_0000 + 32'(i));
        end
        step(1'b0, 32'h0, 1'b0);
        chk("fill_empty_data", data_rx_packet, 32'h0);
        chk("fill_sticky_ovf", 32'(overflow), 32'h1);

        // Wrap-around with rx_hold toggling every 3 cycles
        for (int c = 0; c < 20; c++) step(1'b1, 32'h0003_1000 + 32'(c), 1'((c / 3) % 2));
        drain();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: dst = 16'h0003;
                4, 5:       dst = 16'hFFFF;
                6, 7:       dst = 16'h0005;
                default:    dst = 16'($urandom);
            endcase
            pkt = {dst, 16'($urandom)};
            if (r == 9) pkt = 32'h0;
            step(1'($urandom_range(0, 3) != 0), pkt, 1'($urandom_range(0, 9) < 4));
        end
        drain();

        // Reset mid-operation
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0003_5000 + 32'(i), 1'b1);
        step(1'b0, 32'h0, 1'b0);
        chk("midrst_pre_data",  data_rx_packet, 32'h0003_5000);
        chk("midrst_pre_count", 32'(fifo_count), 32'h3);
        rx_hold = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("midrst_count",    32'(fifo_count), 32'h0);
        chk("midrst_data",     data_rx_packet, 32'h0);
        chk("midrst_ready",    32'(link_ready), 32'h1);
        chk("midrst_overflow", 32'(overflow), 32'h0);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0);
            chk("midrst_after_data", data_rx_packet, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
